// File: rtl/mcu_spi_arbiter.sv
// mcu_spi_arbiter
// Shares the single cartridge-to-MCU SPI link between two SPI engines.
// Port 0 is the RTC command engine and port 1 is the generic MCU command engine.
// The link is granted to one owner per transaction. Simultaneous requests are
// resolved round-robin. A chip-select-high gap is enforced between transactions.
// A hold watchdog revokes an owner that keeps the link too long.
//
// Ports (all logic in the SClk domain, rising edge):
//   SClk, nReset                 clock, asynchronous active-low reset
//   ReqN, nSelN, DoN,            per-engine request level, chip select,
//   ClkRunN, ClkStretchN         MOSI, clock enable and clock stretch
//   Gnt0, Gnt1, Owner            registered grant status (Owner: 01 / 10 / 00)
//   nMCUSel, SPIDo,              link outputs, muxed combinationally from the
//   SPIClkRunning, SPIClkStretch current owner; idle values otherwise
//   Timeout, TimeoutClr          sticky watchdog flag and its single-cycle clear
//   DbgState                     current arbiter state (IDLE/GRANT0/GRANT1/GAP)
//
// Handshake: an engine raises Req and holds it until it has raised nSel again.
// It lowers nSel only after its Gnt is high. The grant ends on the first edge
// that sees the owner's nSel high, provided the owner has either lowered nSel
// during this grant or has already dropped Req.
module mcu_spi_arbiter #(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 4096,
  parameter int HOLD_W     = 13
) (
  input  logic       SClk,
  input  logic       nReset,
  input  logic       Req0,
  input  logic       nSel0,
  input  logic       Do0,
  input  logic       ClkRun0,
  input  logic       ClkStretch0,
  output logic       Gnt0,
  input  logic       Req1,
  input  logic       nSel1,
  input  logic       Do1,
  input  logic       ClkRun1,
  input  logic       ClkStretch1,
  output logic       Gnt1,
  output logic       nMCUSel,
  output logic       SPIDo,
  output logic       SPIClkRunning,
  output logic       SPIClkStretch,
  output logic [1:0] Owner,
  output logic       Timeout,
  input  logic       TimeoutClr,
  output logic [1:0] DbgState
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam bit              WD_EN      = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WD_EN ? MAX_HOLD - 1 : 0);
  localparam logic [3:0]      GAP_LAST   = 4'(GAP_CYCLES - 1);

  state_e              state_q;
  logic                last_owner_q;
  logic                cs_seen_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic [1:0]          owner_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [3:0]          gap_q;
  logic                timeout_q;

  logic in_grant;
  logic own_req;
  logic own_nsel;
  logic normal_rel;
  logic wd_fire;
  logic timeout_set;

  // Owner-side signals used by the release and watchdog logic.
  always_comb begin
    in_grant = (state_q == GRANT0) || (state_q == GRANT1);
    own_req  = (state_q == GRANT1) ? Req1  : Req0;
    own_nsel = (state_q == GRANT1) ? nSel1 : nSel0;
    // Dropping Req before ever asserting nSel is treated as an abandoned
    // grant and releases as soon as nSel is seen high.
    normal_rel  = in_grant && own_nsel && (cs_seen_q || !own_req);
    wd_fire     = in_grant && WD_EN && (hold_q == HOLD_LAST);
    // A normal release wins over a watchdog firing in the same cycle.
    timeout_set = wd_fire && !normal_rel;
  end

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cs_seen_q    <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      owner_q      <= 2'b00;
      hold_q       <= '0;
      gap_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Port 0 wins alone, or on a tie when port 1 was served last.
          if (Req0 && (!Req1 || last_owner_q)) begin
            state_q   <= GRANT0;
            gnt0_q    <= 1'b1;
            owner_q   <= 2'b01;
            cs_seen_q <= 1'b0;
            hold_q    <= '0;
          end else if (Req1) begin
            state_q   <= GRANT1;
            gnt1_q    <= 1'b1;
            owner_q   <= 2'b10;
            cs_seen_q <= 1'b0;
            hold_q    <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (normal_rel || wd_fire) begin
            state_q      <= GAP;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            owner_q      <= 2'b00;
            gap_q        <= '0;
            last_owner_q <= (state_q == GRANT1);
          end else begin
            cs_seen_q <= cs_seen_q || !own_nsel;
            hold_q    <= hold_q + HOLD_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (TimeoutClr) begin
        timeout_q <= 1'b0;
      end
    end
  end

  // Link mux. This is the only combinational input-to-output path.
  // Outside a grant the link rests at its idle values.
  always_comb begin
    nMCUSel       = 1'b1;
    SPIDo         = 1'b1;
    SPIClkRunning = 1'b0;
    SPIClkStretch = 1'b0;
    if (state_q == GRANT0) begin
      nMCUSel       = nSel0;
      SPIDo         = Do0;
      SPIClkRunning = ClkRun0;
      SPIClkStretch = ClkStretch0;
    end else if (state_q == GRANT1) begin
      nMCUSel       = nSel1;
      SPIDo         = Do1;
      SPIClkRunning = ClkRun1;
      SPIClkStretch = ClkStretch1;
    end
  end

  assign Gnt0     = gnt0_q;
  assign Gnt1     = gnt1_q;
  assign Owner    = owner_q;
  assign Timeout  = timeout_q;
  assign DbgState = state_q;

endmodule
